// File: rtl/queue7_21.sv
// queue7_21: 8-entry x 8-bit circular-buffer FIFO with the stack-style
// PushPop/En command port, occupancy counter, empty/full decodes and err.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset, clears all state and storage
//   En       command enable; nothing happens when low
//   PushPop  0 = push IN at the tail, 1 = pop the head (when En=1)
//   IN       push data
//   OUT      head entry (oldest word); 0 when the queue is empty
//   counter  occupancy, 0..DEPTH
//   empty    counter == 0
//   full     counter == DEPTH
//   err      one-cycle registered pulse after a rejected push or pop
module queue7_21 #(
    parameter int N     = 7,
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       En,
    input  logic       PushPop,
    input  logic [N:0] IN,
    output logic [N:0] OUT,
    output logic [N:0] counter,
    output logic       empty,
    output logic       full,
    output logic       err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [N:0] DEPTH_C = (N+1)'(DEPTH);

    logic [N:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic do_push;
    logic do_pop;
    logic reject;

    assign empty = (counter == '0);
    assign full  = (counter == DEPTH_C);

    assign do_push = En & ~PushPop & ~full;
    assign do_pop  = En &  PushPop & ~empty;
    assign reject  = En & ((~PushPop & full) | (PushPop & empty));

    // Head is read straight out of storage; the gating hides stale words
    // left behind by earlier pops when the queue is empty.
    assign OUT = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= IN;
        end
    end

    // Pointers wrap naturally modulo DEPTH; counter tells empty from full
    // since the pointers coincide in both cases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            counter <= '0;
            err     <= 1'b0;
        end else begin
            err <= reject;
            if (do_push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                counter <= counter + (N+1)'(1);
            end else if (do_pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                counter <= counter - (N+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_queue7_21.sv
// tb_queue7_21: scenario-driven bench for queue7_21 with a FIFO
// scoreboard (expected words queued on push, compared on pop).
module tb_queue7_21;

    logic       clk;
    logic       reset;
    logic       En;
    logic       PushPop;
    logic [7:0] IN;
    logic [7:0] OUT;
    logic [7:0] counter;
    logic       empty;
    logic       full;
    logic       err;

    int tests;
    int fails;

    logic [7:0] exp_q[$];

    queue7_21 dut (
        .clk     (clk),
        .reset   (reset),
        .En      (En),
        .PushPop (PushPop),
        .IN      (IN),
        .OUT     (OUT),
        .counter (counter),
        .empty   (empty),
        .full    (full),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        En = 1'b1;
        PushPop = 1'b0;
        IN = d;
        if (exp_q.size() < 8) exp_q.push_back(d);
        @(posedge clk);
        #1;
        En = 1'b0;
    endtask

    // Samples the head just before the pop edge and returns the model's
    // expectation for it (had=0 when the model says the pop is rejected).
    task automatic pop(output logic [7:0] seen, output logic [7:0] want,
                       output bit had);
        @(negedge clk);
        seen = OUT;
        had = (exp_q.size() > 0);
        want = had ? exp_q.pop_front() : 8'h00;
        En = 1'b1;
        PushPop = 1'b1;
        @(posedge clk);
        #1;
        En = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        En = 1'b0;
        PushPop = $urandom_range(0, 1);
        IN = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        En = 1'b0;
        exp_q.delete();
        #2;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        En = 1'b0;
        PushPop = 1'b0;
        IN = 8'h00;
        #3;
        tests++;
        if (counter !== 8'd0 || empty !== 1'b1 || full !== 1'b0 ||
            OUT !== 8'h00 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: cnt=%0d e=%b f=%b out=%h err=%b want 0 1 0 00 0",
                     counter, empty, full, OUT, err);
        end
        @(negedge clk);
        reset = 1'b1;
        idle();
        tests++;
        if (counter !== 8'd0 || empty !== 1'b1 || full !== 1'b0 ||
            OUT !== 8'h00 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: cnt=%0d e=%b f=%b out=%h err=%b want 0 1 0 00 0",
                     counter, empty, full, OUT, err);
        end
    endtask

    task automatic test_fifo_order();
        logic [7:0] s, w;
        bit h;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        tests++;
        if (counter !== 8'd3 || OUT !== 8'h11) begin
            fails++;
            $display("FAIL fifo_fill: cnt=%0d out=%h want 3 11", counter, OUT);
        end
        for (int i = 0; i < 3; i++) begin
            pop(s, w, h);
            tests++;
            if (!h || s !== w || err !== 1'b0) begin
                fails++;
                $display("FAIL fifo_pop%0d: head=%h err=%b want %h 0", i, s, err, w);
            end
        end
        tests++;
        if (OUT !== 8'h00 || empty !== 1'b1 || counter !== 8'd0) begin
            fails++;
            $display("FAIL fifo_drained: out=%h e=%b cnt=%0d want 00 1 0",
                     OUT, empty, counter);
        end
    endtask

    task automatic test_idle_hold();
        logic [7:0] s, w;
        bit h;
        push(8'h5A);
        push(8'hC3);
        for (int i = 0; i < 4; i++) idle();
        tests++;
        if (counter !== 8'd2 || OUT !== 8'h5A || err !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: cnt=%0d out=%h err=%b want 2 5a 0",
                     counter, OUT, err);
        end
        for (int i = 0; i < 2; i++) begin
            pop(s, w, h);
            tests++;
            if (!h || s !== w) begin
                fails++;
                $display("FAIL idle_pop%0d: head=%h want %h", i, s, w);
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] s, w;
        bit h;
        for (int i = 1; i <= 8; i++) push(8'(i));
        tests++;
        if (full !== 1'b1 || counter !== 8'd8 || empty !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL full_flag: f=%b cnt=%0d e=%b err=%b want 1 8 0 0",
                     full, counter, empty, err);
        end
        push(8'hFF);
        tests++;
        if (err !== 1'b1 || counter !== 8'd8 || OUT !== 8'h01) begin
            fails++;
            $display("FAIL full_reject: err=%b cnt=%0d out=%h want 1 8 01",
                     err, counter, OUT);
        end
        idle();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL full_err_pulse: err=%b want 0", err);
        end
        for (int i = 0; i < 8; i++) begin
            pop(s, w, h);
            tests++;
            if (!h || s !== w) begin
                fails++;
                $display("FAIL full_drain%0d: head=%h want %h", i, s, w);
            end
        end
        tests++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            fails++;
            $display("FAIL full_drained: e=%b f=%b want 1 0", empty, full);
        end
    endtask

    task automatic test_pop_empty();
        logic [7:0] s, w;
        bit h;
        apply_reset();
        pop(s, w, h);
        tests++;
        if (h || err !== 1'b1 || counter !== 8'd0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL pop_empty: err=%b cnt=%0d e=%b want 1 0 1",
                     err, counter, empty);
        end
        idle();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL pop_empty_pulse: err=%b want 0", err);
        end
        push(8'h77);
        push(8'h88);
        pop(s, w, h);
        tests++;
        if (!h || s !== w || OUT !== 8'h88) begin
            fails++;
            $display("FAIL pop_empty_ptrs: head=%h next=%h want %h 88", s, OUT, w);
        end
        pop(s, w, h);
    endtask

    task automatic test_wrap();
        logic [7:0] s, w;
        bit h;
        apply_reset();
        for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
        for (int i = 0; i < 6; i++) begin
            pop(s, w, h);
            tests++;
            if (!h || s !== w || err !== 1'b0) begin
                fails++;
                $display("FAIL wrap_pre%0d: head=%h err=%b want %h 0", i, s, err, w);
            end
        end
        for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
        tests++;
        if (counter !== 8'd5 || OUT !== 8'hA0) begin
            fails++;
            $display("FAIL wrap_fill: cnt=%0d out=%h want 5 a0", counter, OUT);
        end
        for (int i = 0; i < 5; i++) begin
            pop(s, w, h);
            tests++;
            if (!h || s !== w || s !== 8'(8'hA0 + i)) begin
                fails++;
                $display("FAIL wrap_pop%0d: head=%h want %h", i, s, w);
            end
        end
        tests++;
        if (empty !== 1'b1 || OUT !== 8'h00) begin
            fails++;
            $display("FAIL wrap_drained: e=%b out=%h want 1 00", empty, OUT);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s, w;
        bit h;
        push(8'h91);
        push(8'h92);
        push(8'h93);
        @(negedge clk);
        En = 1'b1;
        PushPop = 1'b0;
        IN = 8'h94;
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (counter !== 8'd0 || empty !== 1'b1 || full !== 1'b0 ||
            OUT !== 8'h00 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: cnt=%0d e=%b f=%b out=%h err=%b want 0 1 0 00 0",
                     counter, empty, full, OUT, err);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        tests++;
        if (counter !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_hold: cnt=%0d want 0", counter);
        end
        @(negedge clk);
        En = 1'b0;
        reset = 1'b1;
        pop(s, w, h);
        tests++;
        if (h || err !== 1'b1 || counter !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_pop: err=%b cnt=%0d want 1 0", err, counter);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_fifo_order();
        test_idle_hold();
        test_full();
        test_pop_empty();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
